// File: rtl/hv_assoc_search_if.sv
// Query/result handshake bundle for the associative-memory classifier.
// The master side is the upstream bundler plus the result consumer.
interface hv_assoc_search_if #(
  parameter int DIMENSIONS  = 10000,
  parameter int NUM_CLASSES = 2
);
  localparam int IW = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
  localparam int DW = $clog2(DIMENSIONS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIMENSIONS-1:0] query_hv;
  logic [DIMENSIONS-1:0] class_hvs [NUM_CLASSES];
  logic                  out_valid;
  logic                  out_ready;
  logic [IW-1:0]         class_idx;
  logic [DW-1:0]         distance;

  modport master (
    output in_valid, query_hv, class_hvs, out_ready,
    input  in_ready, out_valid, class_idx, distance
  );

  modport slave (
    input  in_valid, query_hv, class_hvs, out_ready,
    output in_ready, out_valid, class_idx, distance
  );
endinterface

// File: rtl/hv_assoc_search.sv
// Nearest-prototype search by Hamming distance, CHUNK bits per cycle.
// state  | meaning
// IDLE   | waiting for a query, in_ready high
// SEARCH | accumulating chunk popcounts class by class
// DONE   | result presented until out_ready
module hv_assoc_search #(
  parameter int DIMENSIONS  = 10000,
  parameter int CHUNK       = 100,
  parameter int NUM_CLASSES = 2
) (
  input logic               clk,
  input logic               nrst,
  hv_assoc_search_if.slave  bus
);
  localparam int K  = DIMENSIONS / CHUNK;
  localparam int DW = $clog2(DIMENSIONS + 1);
  localparam int PW = $clog2(CHUNK + 1);
  localparam int IW = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(K - 1);
  localparam logic [IW-1:0] LAST_CLASS = IW'(NUM_CLASSES - 1);

  generate
    if (DIMENSIONS % CHUNK != 0) begin : g_bad_chunk
      $error("hv_assoc_search: DIMENSIONS must be a multiple of CHUNK");
    end
    if (NUM_CLASSES < 2) begin : g_bad_classes
      $error("hv_assoc_search: NUM_CLASSES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                state;
  logic [DIMENSIONS-1:0] q_reg;
  logic [CW-1:0]         chunk_cnt;
  logic [IW-1:0]         cls_cnt;
  logic [DW-1:0]         acc;
  logic [DW-1:0]         best_dist;
  logic [IW-1:0]         best_idx;

  logic [CHUNK-1:0]      q_chunk;
  logic [CHUNK-1:0]      c_chunk;
  logic [CHUNK-1:0]      diff;
  logic [PW-1:0]         pop;
  logic [DW-1:0]         acc_next;
  logic                  new_best;

  always_comb begin
    q_chunk  = q_reg[int'(chunk_cnt) * CHUNK +: CHUNK];
    c_chunk  = bus.class_hvs[cls_cnt][int'(chunk_cnt) * CHUNK +: CHUNK];
    diff     = q_chunk ^ c_chunk;
    pop      = '0;
    for (int i = 0; i < CHUNK; i++) begin
      pop = pop + PW'(diff[i]);
    end
    acc_next = acc + DW'(pop);
    // strict compare so ties keep the lower class index
    new_best = (acc_next < best_dist);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      q_reg         <= '0;
      chunk_cnt     <= '0;
      cls_cnt       <= '0;
      acc           <= '0;
      best_dist     <= '0;
      best_idx      <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.class_idx <= '0;
      bus.distance  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            q_reg        <= bus.query_hv;
            acc          <= '0;
            chunk_cnt    <= '0;
            cls_cnt      <= '0;
            best_dist    <= '1;
            best_idx     <= '0;
            bus.in_ready <= 1'b0;
            state        <= SEARCH;
          end
        end
        SEARCH: begin
          if (chunk_cnt == LAST_CHUNK) begin
            acc       <= '0;
            chunk_cnt <= '0;
            if (new_best) begin
              best_dist <= acc_next;
              best_idx  <= cls_cnt;
            end
            if (cls_cnt == LAST_CLASS) begin
              bus.class_idx <= new_best ? cls_cnt  : best_idx;
              bus.distance  <= new_best ? acc_next : best_dist;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end else begin
              cls_cnt <= cls_cnt + 1'b1;
            end
          end else begin
            acc       <= acc_next;
            chunk_cnt <= chunk_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hv_assoc_search.sv
// Directed bench for hv_assoc_search at DIMENSIONS=8, CHUNK=4 with 3 and 2 classes.
module tb_hv_assoc_search;
  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;

  hv_assoc_search_if #(.DIMENSIONS(8), .NUM_CLASSES(3)) a_if ();
  hv_assoc_search_if #(.DIMENSIONS(8), .NUM_CLASSES(2)) b_if ();

  hv_assoc_search #(.DIMENSIONS(8), .CHUNK(4), .NUM_CLASSES(3)) dut_a (
    .clk  (clk),
    .nrst (nrst),
    .bus  (a_if.slave)
  );

  hv_assoc_search #(.DIMENSIONS(8), .CHUNK(4), .NUM_CLASSES(2)) dut_b (
    .clk  (clk),
    .nrst (nrst),
    .bus  (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic send_a(input logic [7:0] q, input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2, input bit hold);
    int t;
    a_if.query_hv     = q;
    a_if.class_hvs[0] = c0;
    a_if.class_hvs[1] = c1;
    a_if.class_hvs[2] = c2;
    a_if.in_valid     = 1'b1;
    t = 0;
    while (!a_if.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("a_ready_before_accept", a_if.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) a_if.in_valid = 1'b0;
  endtask

  // Counts rising edges from the accept edge until out_valid is seen.
  task automatic wait_a(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!a_if.out_valid && k < 40);
  endtask

  task automatic consume_a();
    a_if.out_ready = 1'b1;
    @(negedge clk);
    check("a_consume_valid_low", a_if.out_valid, 0);
    check("a_consume_ready_high", a_if.in_ready, 1);
    a_if.out_ready = 1'b0;
  endtask

  initial begin
    int k;
    int seen;
    n_checks = 0;
    n_fail   = 0;
    nrst = 1'b0;
    a_if.in_valid = 1'b0; a_if.out_ready = 1'b0; a_if.query_hv = '0;
    b_if.in_valid = 1'b0; b_if.out_ready = 1'b0; b_if.query_hv = '0;
    for (int i = 0; i < 3; i++) a_if.class_hvs[i] = '0;
    for (int i = 0; i < 2; i++) b_if.class_hvs[i] = '0;

    #12;
    check("rst_in_ready", a_if.in_ready, 1);
    check("rst_out_valid", a_if.out_valid, 0);
    check("rst_class_idx", a_if.class_idx, 0);
    check("rst_distance", a_if.distance, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // exact match, then held under backpressure with a stray request
    send_a(8'hF0, 8'hF0, 8'h0F, 8'hF1, 1'b0);
    wait_a(k);
    check("exact_latency", k, 6);
    check("exact_idx", a_if.class_idx, 0);
    check("exact_dist", a_if.distance, 0);
    a_if.in_valid = 1'b1;
    a_if.query_hv = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) a_if.in_valid = 1'b0;
      check("bp_out_valid", a_if.out_valid, 1);
      check("bp_in_ready", a_if.in_ready, 0);
      check("bp_idx", a_if.class_idx, 0);
      check("bp_dist", a_if.distance, 0);
    end
    consume_a();
    @(negedge clk);
    check("bp_no_stray_search", a_if.in_ready, 1);
    check("bp_no_stray_valid", a_if.out_valid, 0);

    // tie between classes 1 and 2 at distance 1
    send_a(8'h00, 8'h03, 8'h01, 8'h02, 1'b0);
    wait_a(k);
    check("tie_latency", k, 6);
    check("tie_idx", a_if.class_idx, 1);
    check("tie_dist", a_if.distance, 1);
    consume_a();
    check("idle_hold_idx", a_if.class_idx, 1);
    check("idle_hold_dist", a_if.distance, 1);

    // maximum distance on the two-class instance
    b_if.query_hv     = 8'hFF;
    b_if.class_hvs[0] = 8'h00;
    b_if.class_hvs[1] = 8'h00;
    b_if.in_valid     = 1'b1;
    check("b_ready", b_if.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    b_if.in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!b_if.out_valid && k < 40);
    check("max_latency", k, 4);
    check("max_idx", b_if.class_idx, 0);
    check("max_dist", b_if.distance, 8);
    b_if.out_ready = 1'b1;
    @(negedge clk);
    check("max_consume", b_if.out_valid, 0);
    b_if.out_ready = 1'b0;

    // reset dropped between edges partway through a search
    send_a(8'h00, 8'h03, 8'h01, 8'h02, 1'b0);
    repeat (3) @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check("midrst_in_ready", a_if.in_ready, 1);
    check("midrst_out_valid", a_if.out_valid, 0);
    check("midrst_idx", a_if.class_idx, 0);
    check("midrst_dist", a_if.distance, 0);
    @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_if.out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);
    send_a(8'h0F, 8'hF0, 8'h0F, 8'hFF, 1'b0);
    wait_a(k);
    check("after_rst_latency", k, 6);
    check("after_rst_idx", a_if.class_idx, 1);
    check("after_rst_dist", a_if.distance, 0);
    consume_a();

    // back-to-back; query changes after the first accept to prove it is latched
    a_if.out_ready = 1'b1;
    send_a(8'h0F, 8'hF0, 8'h0F, 8'hF1, 1'b1);
    a_if.query_hv = 8'hF1;
    wait_a(k);
    check("b2b1_latency", k, 6);
    check("b2b1_idx", a_if.class_idx, 1);
    check("b2b1_dist", a_if.distance, 0);
    @(negedge clk);
    check("b2b_bubble_valid", a_if.out_valid, 0);
    check("b2b_bubble_ready", a_if.in_ready, 1);
    @(negedge clk);
    check("b2b_second_accept", a_if.in_ready, 0);
    a_if.in_valid = 1'b0;
    wait_a(k);
    check("b2b2_latency", k, 6);
    check("b2b2_idx", a_if.class_idx, 2);
    check("b2b2_dist", a_if.distance, 0);
    @(negedge clk);
    check("b2b2_pulse_end", a_if.out_valid, 0);
    a_if.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hv_assoc_search.md
Name: hv_assoc_search

Overview:
- Associative-memory classifier stage that sits directly downstream of the channel bundler.
- Accepts one bundled query hypervector and compares it against NUM_CLASSES stored class prototypes (e.g. seizure / non-seizure) by Hamming distance.
- Processes CHUNK bits per cycle, so popcount logic stays small at DIMENSIONS=10000.
- Reports the index of the nearest class and its distance through a valid/ready handshake.

Parameters:
- DIMENSIONS, 10000, hypervector width in bits.
- CHUNK, 100, bits compared per cycle; DIMENSIONS must be an exact multiple of CHUNK (elaboration-time error otherwise).
- NUM_CLASSES, 2, number of class prototypes; must be ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nrst  input  1  asynchronous active-low reset.
- in_valid  input  1  query_hv is valid.
- in_ready  output  1  block can accept a query.
- query_hv  input  DIMENSIONS  bundled query hypervector (bundler hvout).
- class_hvs  input  [DIMENSIONS-1:0] x NUM_CLASSES (unpacked array)  class prototypes; must be held stable while busy.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- class_idx  output  max(1,$clog2(NUM_CLASSES))  index of the nearest class.
- distance  output  $clog2(DIMENSIONS+1)  Hamming distance to the nearest class.

Behaviour:
- Async reset (nrst=0) clears everything immediately, regardless of clock:
  - state=IDLE, in_ready=1, out_valid=0, class_idx=0, distance=0.
  - All counters and accumulators cleared.
  - Reset mid-search aborts the search; no result is produced.
- K = DIMENSIONS/CHUNK. Internal state: chunk counter (0..K-1), class counter (0..NUM_CLASSES-1), running accumulator acc, best_dist, best_idx.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch query_hv into an internal register, clear acc and both counters, set best_dist=all-ones, go to SEARCH.
- SEARCH:
  - in_ready=0.
  - Each cycle: acc_next = acc + popcount(q[chunk*CHUNK +: CHUNK] ^ class_hvs[cls][chunk*CHUNK +: CHUNK]). Chunk 0 is the LSB chunk.
  - Last chunk of a class: if acc_next < best_dist, update best_dist and best_idx=cls. Strictly-less rule: ties keep the lower index. Then clear acc, reset the chunk counter, increment cls.
  - Last chunk of the last class: apply the same compare, load class_idx/distance from the final best values, set out_valid=1, go to DONE.
- Latency: exactly NUM_CLASSES*K rising edges from the accept edge to out_valid=1.
- DONE:
  - out_valid=1; class_idx and distance held constant until out_ready=1.
  - On out_valid&&out_ready: out_valid=0, go to IDLE. in_ready=1 from the next cycle, so there is a one-cycle bubble between queries.
  - in_valid is ignored in SEARCH and DONE; the upstream stage must hold its request.
- Widths:
  - acc and best_dist are $clog2(DIMENSIONS+1) bits. Maximum distance DIMENSIONS fits without overflow.
  - Per-chunk popcount is $clog2(CHUNK+1) bits, zero-extended before the add.
- class_idx and distance change only on the DONE transition or on reset. They keep the last result while in IDLE/SEARCH; only out_valid qualifies them.
- Changing class_hvs during SEARCH produces an undefined result. The query is latched, so query_hv may change after acceptance.

Test Plan (DIMENSIONS=8, CHUNK=4, NUM_CLASSES=3 unless stated):
1. Exact match: query 8'hF0; classes {8'hF0, 8'h0F, 8'hF1} -> out_valid rises 6 edges after accept; class_idx=0, distance=0.
2. Tie break: query 8'h00; classes {8'h03, 8'h01, 8'h02} -> class_idx=1, distance=1 (classes 1 and 2 tie; lower index wins).
3. Maximum distance, NUM_CLASSES=2: query 8'hFF; classes {8'h00, 8'h00} -> class_idx=0, distance=8, with no wrap.
4. Backpressure: as case 1 but out_ready=0 for 5 cycles -> outputs stable, in_ready=0, a second in_valid is ignored. Raise out_ready -> out_valid drops next edge, in_ready=1 the following cycle.
5. Reset mid-search: drop nrst 3 edges after accept, asynchronously between edges -> outputs go to 0 / in_ready=1 immediately, with no out_valid. A new query 8'h0F with classes {8'hF0, 8'h0F, 8'hFF} then yields class_idx=1, distance=0.
6. Back-to-back: two queries 8'h0F then 8'hF1 with out_ready held high and classes as case 1 -> results (idx1, d0) then (idx2, d0), with exactly one idle cycle between out_valid pulses and acceptance.
